// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between fetch reads and load/store
//            traffic and returns read data to its owner after MEM_LAT cycles.
//            Optional macro ARB_ROUND_ROBIN_EN swaps the starvation FSM for
//            a last-winner round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                fetch_stall,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int c_BE_W = DATA_W / 8;
  localparam int c_TAIL = MEM_LAT - 1;

  logic w_if_req;
  logic w_ls_req;
  logic w_if_gnt;
  logic w_ls_gnt;

  // Flush makes fetch look idle to the arbiter; reset blocks every grant.
  assign w_if_req = if_req & ~flush & ~rst;
  assign w_ls_req = ls_req & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_ls;

  assign w_if_gnt = w_if_req & (~w_ls_req | r_last_ls);
  assign w_ls_gnt = w_ls_req & ~w_if_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_ls <= 1'b1;
    end else if (w_if_gnt | w_ls_gnt) begin
      r_last_ls <= w_ls_gnt;
    end
  end
`else
  typedef enum logic [0:0] {
    ST_NORMAL      = 1'b0,
    ST_FETCH_FORCE = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = (r_starve_cnt == 4'hF) ? 4'hF : r_starve_cnt + 4'd1;

  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (r_state == ST_FETCH_FORCE) begin
      w_if_gnt = w_if_req;
      w_ls_gnt = w_ls_req & ~w_if_req;
    end else begin
      w_ls_gnt = w_ls_req;
      w_if_gnt = w_if_req & ~w_ls_req;
    end
  end

  // FETCH_FORCE lasts exactly one cycle: either fetch wins it or fetch has
  // gone idle, and both cases return to NORMAL with a cleared count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= '0;
    end else if (r_state == ST_FETCH_FORCE) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= '0;
    end else if (w_if_req & w_ls_gnt) begin
      r_starve_cnt <= w_cnt_inc;
      if (w_cnt_inc >= 4'(STARVE_MAX)) begin
        r_state <= ST_FETCH_FORCE;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end
`endif

  assign if_gnt      = w_if_gnt;
  assign ls_gnt      = w_ls_gnt;
  assign fetch_stall = if_req & ~w_if_gnt & ~rst;

  assign mem_en    = w_if_gnt | w_ls_gnt;
  assign mem_we    = w_ls_gnt & ls_we;
  assign mem_be    = mem_we ? ls_be : {c_BE_W{mem_en}};
  assign mem_addr  = w_if_gnt ? if_addr : (w_ls_gnt ? ls_addr : '0);
  assign mem_wdata = mem_we ? ls_wdata : '0;

  // Tag pipeline: bit 0 is the newest entry, bit c_TAIL lines up with mem_rdata.
  logic [MEM_LAT-1:0] r_vld;
  logic [MEM_LAT-1:0] r_own_ls;
  logic [MEM_LAT-1:0] r_live;
  logic [MEM_LAT-1:0] w_kill;
  logic               w_rd_gnt;
  logic               w_tail_live;

  assign w_rd_gnt    = w_if_gnt | (w_ls_gnt & ~ls_we);
  assign w_kill      = {MEM_LAT{flush}} & r_vld & ~r_own_ls;
  assign w_tail_live = r_vld[c_TAIL] & r_live[c_TAIL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld    <= '0;
      r_own_ls <= '0;
      r_live   <= '0;
    end else begin
      r_vld    <= MEM_LAT'({r_vld, w_rd_gnt});
      r_own_ls <= MEM_LAT'({r_own_ls, w_ls_gnt});
      r_live   <= MEM_LAT'({r_live & ~w_kill, 1'b1});
    end
  end

  assign if_rvalid = w_tail_live & ~r_own_ls[c_TAIL] & ~flush & ~rst;
  assign ls_rvalid = w_tail_live & r_own_ls[c_TAIL] & ~rst;

  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      if (if_rvalid) r_if_rdata <= mem_rdata;
      if (ls_rvalid) r_ls_rdata <= mem_rdata;
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : r_if_rdata;
  assign ls_rdata = ls_rvalid ? mem_rdata : r_ls_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized and directed bench for mem_arbiter against a
//            transaction-level model with its own memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              if_req, if_gnt, if_rvalid, fetch_stall;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .fetch_stall(fetch_stall),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory macro: responds to whatever the DUT issues, MEM_LAT cycles later.
  logic [31:0] phy [logic [31:0]];
  logic [31:0] dl [MEM_LAT];
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = $urandom();
    if (mem_en && mem_we)
      phy[mem_addr] = merge(phy.exists(mem_addr) ? phy[mem_addr] : init_val(mem_addr), mem_wdata, mem_be);
    else if (mem_en)
      dl[0] = phy.exists(mem_addr) ? phy[mem_addr] : init_val(mem_addr);
    mem_rdata <= dl[MEM_LAT-1];
  end

  // Reference model: responses indexed by the cycle they are due.
  logic [31:0] ref_mem [logic [31:0]];
  bit          rsp_v [8];
  bit          rsp_ls [8];
  logic [31:0] rsp_dat [8];
  logic [31:0] hold_if, hold_ls;
`ifdef ARB_ROUND_ROBIN_EN
  bit          last_ls;
`else
  int          losses;
`endif
  int          cyc;
  bit          e_if_gnt, e_ls_gnt;
  bit          obs_if_gnt, obs_if_rv, obs_ls_rv;
  bit          if_pend, ls_pend;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rsp_v[i] = 1'b0;
    hold_if = '0;
    hold_ls = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_ls = 1'b1;
`else
    losses = 0;
`endif
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step();
    bit eff_if, e_if_rv, e_ls_rv;
    int s, d;
    #3;
    eff_if = if_req && !flush;
`ifdef ARB_ROUND_ROBIN_EN
    e_if_gnt = eff_if && (!ls_req || last_ls);
`else
    e_if_gnt = eff_if && (!ls_req || losses >= STARVE_MAX);
`endif
    e_ls_gnt = ls_req && !e_if_gnt;
    if (flush)
      for (int k = 0; k < MEM_LAT; k++) begin
        d = (cyc + k) % 8;
        if (!rsp_ls[d]) rsp_v[d] = 1'b0;
      end
    s = cyc % 8;
    e_if_rv = rsp_v[s] && !rsp_ls[s];
    e_ls_rv = rsp_v[s] && rsp_ls[s];
    if (e_if_rv) hold_if = rsp_dat[s];
    if (e_ls_rv) hold_ls = rsp_dat[s];
    rsp_v[s] = 1'b0;

    obs_if_gnt = if_gnt;
    obs_if_rv  = if_rvalid;
    obs_ls_rv  = ls_rvalid;
    check("ctl", 64'({if_gnt, ls_gnt, fetch_stall, mem_en, mem_we}),
          64'({e_if_gnt, e_ls_gnt, if_req && !e_if_gnt, e_if_gnt || e_ls_gnt, e_ls_gnt && ls_we}));
    check("rvalid", 64'({if_rvalid, ls_rvalid}), 64'({e_if_rv, e_ls_rv}));
    check("if_rdata", 64'(if_rdata), 64'(hold_if));
    check("ls_rdata", 64'(ls_rdata), 64'(hold_ls));
    if (e_if_gnt) check("mem_addr_if", 64'(mem_addr), 64'(if_addr));
    else if (e_ls_gnt) check("mem_addr_ls", 64'(mem_addr), 64'(ls_addr));
    if (e_ls_gnt && ls_we) check("mem_wr", 64'({mem_be, mem_wdata}), 64'({ls_be, ls_wdata}));

    d = (cyc + MEM_LAT) % 8;
    if (e_if_gnt) begin
      rsp_v[d] = 1'b1; rsp_ls[d] = 1'b0; rsp_dat[d] = ref_rd(if_addr);
    end else if (e_ls_gnt && !ls_we) begin
      rsp_v[d] = 1'b1; rsp_ls[d] = 1'b1; rsp_dat[d] = ref_rd(ls_addr);
    end else if (e_ls_gnt) begin
      ref_mem[ls_addr] = merge(ref_rd(ls_addr), ls_wdata, ls_be);
    end
`ifdef ARB_ROUND_ROBIN_EN
    if (e_if_gnt || e_ls_gnt) last_ls = e_ls_gnt;
`else
    losses = (eff_if && e_ls_gnt) ? ((losses < 15) ? losses + 1 : 15) : 0;
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_drive(input int p_if, input int p_ls, input int p_fl);
    if (e_if_gnt) if_pend = 1'b0;
    if (e_ls_gnt) ls_pend = 1'b0;
    if (!if_pend && $urandom_range(0, 99) < p_if) begin
      if_pend = 1'b1;
      if_addr = 32'h100 + 32'($urandom_range(0, 15) << 2);
    end
    if (!ls_pend && $urandom_range(0, 99) < p_ls) begin
      ls_pend  = 1'b1;
      ls_we    = 1'($urandom_range(0, 1));
      ls_addr  = 32'h100 + 32'($urandom_range(0, 15) << 2);
      ls_wdata = $urandom();
      ls_be    = 4'($urandom_range(1, 15));
    end
    if_req = if_pend;
    ls_req = ls_pend;
    flush  = ($urandom_range(0, 99) < p_fl);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({if_gnt, ls_gnt, fetch_stall, mem_en, mem_we, mem_be, if_rvalid, ls_rvalid}), 64'd0);
    check({tag, "_rdata"}, 64'({if_rdata, ls_rdata}), 64'd0);
    check({tag, "_mem"}, 64'({mem_addr, mem_wdata}), 64'd0);
  endtask

  int n_if;

  initial begin
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h104; ls_addr = 32'h108;
    #1;
    check_zero("reset");
    if_req = 1'b0; ls_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single fetch
    phy[32'h100]     = 32'h00500093;
    ref_mem[32'h100] = 32'h00500093;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_req = 1'b0;
    repeat (MEM_LAT) step();
    check("fetch_data", 64'(if_rdata), 64'h00500093);

    // Write then read
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF; ls_be = 4'hF;
    step();
    ls_we = 1'b0;
    step();
    ls_req = 1'b0;
    repeat (MEM_LAT) step();
    check("ls_wr_rd", 64'(ls_rdata), 64'hDEADBEEF);

    // Starvation: fetch should win every fifth contended cycle
    n_if = 0;
    if_addr = 32'h104; ls_addr = 32'h108;
    for (int i = 0; i < 10; i++) begin
      if_req = 1'b1; ls_req = 1'b1;
      step();
      n_if += int'(obs_if_gnt);
    end
    check("starve_if_wins", 64'(n_if), 64'd2);
    if_req = 1'b0; ls_req = 1'b0;
    repeat (MEM_LAT) step();

    // Flush squash
    if_req = 1'b1; if_addr = 32'h104;
    step();
    if_addr = 32'h108;
    step();
    if_req = 1'b0; flush = 1'b1; ls_req = 1'b1; ls_addr = 32'h200;
    step();
    flush = 1'b0; ls_req = 1'b0;
    n_if = 0;
    repeat (2) begin
      step();
      n_if += int'(obs_if_rv);
    end
    check("flush_squash", 64'(n_if), 64'd0);
    step();
    check("flush_ls_rv", 64'(obs_ls_rv), 64'd1);
    check("flush_ls_data", 64'(ls_rdata), 64'hDEADBEEF);

    // Random traffic
    if_pend = 1'b0; ls_pend = 1'b0; e_if_gnt = 1'b0; e_ls_gnt = 1'b0;
    repeat (400) begin
      rand_drive(60, 60, 8);
      step();
    end

    // Reset with reads in flight
    repeat (4) begin
      rand_drive(100, 100, 0);
      step();
    end
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (400) begin
      rand_drive(70, 70, 5);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
